// File: rtl/karatsuba_mul_stream.sv
// karatsuba_mul_stream: five-stage Karatsuba multiplier with per-beat signed or
// unsigned mode, valid/ready on both sides and a credit-guarded output FIFO.
// Stages never stall. ready_o only admits a beat that is already guaranteed a
// FIFO slot, so the pipeline can always push its S5 result.
module karatsuba_mul_stream #(
  parameter int WIDTH      = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic [TAG_W-1:0]     tag_o
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int UW = CW + 3;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_neg;
  logic [2*H+1:0]       w_mid;
  logic [W2-1:0]        w_p;
  logic                 w_push;
  logic                 w_pop;
  logic [2:0]           w_inflight;
  logic [UW-1:0]        w_used;

  logic                 r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid, r_s5_valid;
  logic                 r_s1_neg, r_s2_neg, r_s3_neg, r_s4_neg;
  logic [TAG_W-1:0]     r_s1_tag, r_s2_tag, r_s3_tag, r_s4_tag, r_s5_tag;
  logic [WIDTH-1:0]     r_s1_ma, r_s1_mb;
  logic [H-1:0]         r_s2_ah, r_s2_al, r_s2_bh, r_s2_bl;
  logic [H:0]           r_s2_sa, r_s2_sb;
  logic [2*H-1:0]       r_s3_z2, r_s3_z0;
  logic [2*H+1:0]       r_s3_z1;
  logic [W2-1:0]        r_s4_p;
  logic [W2-1:0]        r_s5_res;

  logic [W2-1:0]        r_mem_prod [FIFO_DEPTH];
  logic [TAG_W-1:0]     r_mem_tag  [FIFO_DEPTH];
  logic [PW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;

  // The magnitude of the most-negative value is 2^(W-1), which still fits in W unsigned bits
  assign w_accept = valid_i && ready_o;
  assign w_mag_a  = (signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
  assign w_mag_b  = (signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
  assign w_neg    = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);

  // Karatsuba middle term and recombination of the three partial products
  assign w_mid = r_s3_z1 - (2*H+2)'(r_s3_z2) - (2*H+2)'(r_s3_z0);
  assign w_p   = (W2'(r_s3_z2) << WIDTH) + (W2'(w_mid) << H) + W2'(r_s3_z0);

  // Stage valid bits advance unconditionally; reset discards everything in flight
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s4_valid <= 1'b0;
      r_s5_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      r_s4_valid <= r_s3_valid;
      r_s5_valid <= r_s4_valid;
    end
  end

  // Datapath: sign/magnitude, split, partial products, combine, sign fix
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_s1_neg <= 1'b0; r_s1_tag <= '0; r_s1_ma <= '0; r_s1_mb <= '0;
      r_s2_neg <= 1'b0; r_s2_tag <= '0;
      r_s2_ah  <= '0;   r_s2_al  <= '0; r_s2_bh <= '0; r_s2_bl <= '0;
      r_s2_sa  <= '0;   r_s2_sb  <= '0;
      r_s3_neg <= 1'b0; r_s3_tag <= '0;
      r_s3_z2  <= '0;   r_s3_z0  <= '0; r_s3_z1 <= '0;
      r_s4_neg <= 1'b0; r_s4_tag <= '0; r_s4_p  <= '0;
      r_s5_tag <= '0;   r_s5_res <= '0;
    end else begin
      r_s1_neg <= w_neg;
      r_s1_tag <= tag_i;
      r_s1_ma  <= w_mag_a;
      r_s1_mb  <= w_mag_b;

      r_s2_neg <= r_s1_neg;
      r_s2_tag <= r_s1_tag;
      r_s2_ah  <= r_s1_ma[WIDTH-1:H];
      r_s2_al  <= r_s1_ma[H-1:0];
      r_s2_bh  <= r_s1_mb[WIDTH-1:H];
      r_s2_bl  <= r_s1_mb[H-1:0];
      r_s2_sa  <= {1'b0, r_s1_ma[WIDTH-1:H]} + {1'b0, r_s1_ma[H-1:0]};
      r_s2_sb  <= {1'b0, r_s1_mb[WIDTH-1:H]} + {1'b0, r_s1_mb[H-1:0]};

      r_s3_neg <= r_s2_neg;
      r_s3_tag <= r_s2_tag;
      r_s3_z2  <= (2*H)'(r_s2_ah) * (2*H)'(r_s2_bh);
      r_s3_z0  <= (2*H)'(r_s2_al) * (2*H)'(r_s2_bl);
      r_s3_z1  <= (2*H+2)'(r_s2_sa) * (2*H+2)'(r_s2_sb);

      r_s4_neg <= r_s3_neg;
      r_s4_tag <= r_s3_tag;
      r_s4_p   <= w_p;

      r_s5_tag <= r_s4_tag;
      r_s5_res <= r_s4_neg ? (~r_s4_p + W2'(1)) : r_s4_p;
    end
  end

  // Credit check: a beat is admitted only if every in-flight result still has a FIFO slot
  assign w_inflight = 3'(r_s1_valid) + 3'(r_s2_valid) + 3'(r_s3_valid)
                    + 3'(r_s4_valid) + 3'(r_s5_valid);
  assign w_used     = UW'(w_inflight) + UW'(r_count);
  assign ready_o    = (w_used < UW'(FIFO_DEPTH));

  assign w_push = r_s5_valid;
  assign w_pop  = (r_count != '0) && ready_i;

  // FIFO storage is written straight from S5; entries need no reset because count gates them
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_prod[r_wptr] <= r_s5_res;
      r_mem_tag[r_wptr]  <= r_s5_tag;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Fall-through head; outputs read zero whenever the FIFO is empty
  assign valid_o   = (r_count != '0);
  assign product_o = valid_o ? r_mem_prod[r_rptr] : '0;
  assign tag_o     = valid_o ? r_mem_tag[r_rptr]  : '0;

endmodule

// File: tb/tb_karatsuba_mul_stream.sv
// tb_karatsuba_mul_stream: checks karatsuba_mul_stream against a plain-arithmetic
// reference product kept in an ordered queue of outstanding beats.
module tb_karatsuba_mul_stream;

  localparam int WIDTH      = 24;
  localparam int FIFO_DEPTH = 8;
  localparam int TAG_W      = 4;
  localparam int W2         = 2 * WIDTH;

  logic               clk_i;
  logic               rstn_i;
  logic               valid_i;
  logic               ready_o;
  logic               signed_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic [TAG_W-1:0]   tag_i;
  logic               valid_o;
  logic               ready_i;
  logic [W2-1:0]      product_o;
  logic [TAG_W-1:0]   tag_o;

  int totalChecks = 0;
  int badChecks   = 0;
  int popCount    = 0;

  logic [W2-1:0]    qProd[$];
  logic [TAG_W-1:0] qTag[$];

  karatsuba_mul_stream #(
    .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .valid_i(valid_i), .ready_o(ready_o), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .product_o(product_o), .tag_o(tag_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: sign- or zero-extend both operands, multiply, keep the low 2*WIDTH bits
  function automatic logic [W2-1:0] refProduct(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic s);
    logic signed [W2+1:0] ea, eb, pr;
    ea = s ? {{(W2+2-WIDTH){a[WIDTH-1]}}, a} : {{(W2+2-WIDTH){1'b0}}, a};
    eb = s ? {{(W2+2-WIDTH){b[WIDTH-1]}}, b} : {{(W2+2-WIDTH){1'b0}}, b};
    pr = ea * eb;
    return pr[W2-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every pop is checked against the oldest outstanding beat
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      qProd.delete();
      qTag.delete();
    end else begin
      if (valid_o && ready_i) begin
        popCount++;
        if (qProd.size() == 0) begin
          totalChecks++;
          badChecks++;
          $display("[TB] FAIL stale_result: got product 0x%0h tag %0d, expected no result", product_o, tag_o);
        end else begin
          checkOutput("product", 64'(product_o), 64'(qProd[0]));
          checkOutput("tag", 64'(tag_o), 64'(qTag[0]));
          void'(qProd.pop_front());
          void'(qTag.pop_front());
        end
      end
      if (dut.r_s5_valid && (int'(dut.r_count) == FIFO_DEPTH) && !(valid_o && ready_i)) begin
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL push_when_full: got push with count %0d, expected no push", dut.r_count);
      end
      if (valid_i && ready_o) begin
        qProd.push_back(refProduct(a_i, b_i, signed_i));
        qTag.push_back(tag_i);
      end
    end
  end

  // Present one beat and hold it until the block accepts it
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s, input logic [TAG_W-1:0] t);
    logic ok;
    ok       = 1'b0;
    a_i      = a;
    b_i      = b;
    signed_i = s;
    tag_i    = t;
    valid_i  = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      ok = ready_o;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    if (!ok) begin
      totalChecks++;
      badChecks++;
      $display("[TB] FAIL accept_timeout: got ready_o=0 for 200 cycles, expected acceptance");
    end
  endtask

  task automatic drainAll();
    ready_i = 1'b1;
    for (int k = 0; k < 200 && qProd.size() != 0; k++) begin
      @(posedge clk_i);
      #1;
    end
    checkOutput("drain_outstanding", 64'(qProd.size()), 64'd0);
    checkOutput("drain_valid_o", 64'(valid_o), 64'd0);
  endtask

  task automatic randomOperand(output logic [WIDTH-1:0] v);
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0)      v = {1'b1, {(WIDTH-1){1'b0}}};
    else if (sel == 1) v = '1;
    else               v = WIDTH'($urandom);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int acc;
    int popBase;
    int sent;
    logic ok;
    logic [WIDTH-1:0] ra, rb;

    rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; signed_i = 1'b0;
    a_i = '0; b_i = '0; tag_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_valid_o", 64'(valid_o), 64'd0);
    checkOutput("reset_product_o", 64'(product_o), 64'd0);
    checkOutput("reset_tag_o", 64'(tag_o), 64'd0);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("reset_ready_o", 64'(ready_o), 64'd1);

    // Pin the reference model with hand-computed products
    checkOutput("model_corner", 64'(refProduct(24'h800000, 24'h800000, 1'b1)), 64'h4000_0000_0000);
    checkOutput("model_uu_max", 64'(refProduct(24'hFFFFFF, 24'hFFFFFF, 1'b0)), 64'hFFFF_FE00_0001);
    checkOutput("model_ss_m1", 64'(refProduct(24'hFFFFFF, 24'hFFFFFF, 1'b1)), 64'h0000_0000_0001);
    checkOutput("model_neg", 64'(refProduct(24'hFFFFFF, 24'h000001, 1'b1)), 64'hFFFF_FFFF_FFFF);
    checkOutput("model_small", 64'(refProduct(24'h000003, 24'hFFFFFE, 1'b1)), 64'hFFFF_FFFF_FFFA);

    // Signed corner and latency from an empty FIFO
    ready_i = 1'b1;
    applyStimulus(24'h800000, 24'h800000, 1'b1, 4'd5);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) begin
        lat = k;
        break;
      end
    end
    checkOutput("corner_latency", 64'(lat), 64'd5);
    checkOutput("corner_product", 64'(product_o), 64'h4000_0000_0000);
    checkOutput("corner_tag", 64'(tag_o), 64'd5);
    drainAll();

    // Mixed modes back to back; results queue behind a stalled consumer
    ready_i = 1'b0;
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'd1);
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 1'b1, 4'd2);
    applyStimulus(24'hFFFFFF, 24'h000001, 1'b1, 4'd3);
    repeat (6) @(posedge clk_i);
    #1;
    checkOutput("mixed_head_valid", 64'(valid_o), 64'd1);
    checkOutput("mixed_head_tag", 64'(tag_o), 64'd1);
    checkOutput("mixed_head_product", 64'(product_o), 64'hFFFF_FE00_0001);
    drainAll();

    // Backpressure: continuous valid_i with ready_i low accepts exactly FIFO_DEPTH beats
    ready_i = 1'b0;
    acc = 0;
    randomOperand(ra); randomOperand(rb);
    a_i = ra; b_i = rb; signed_i = 1'($urandom); tag_i = TAG_W'($urandom);
    valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ok = ready_o;
      @(posedge clk_i);
      #1;
      if (ok) begin
        acc++;
        randomOperand(ra); randomOperand(rb);
        a_i = ra; b_i = rb; signed_i = 1'($urandom); tag_i = TAG_W'($urandom);
      end
    end
    valid_i = 1'b0;
    checkOutput("stall_accepted", 64'(acc), 64'(FIFO_DEPTH));
    checkOutput("stall_ready_o", 64'(ready_o), 64'd0);
    // The last accepted beat now sits in S5 while the FIFO holds the rest
    checkOutput("pushpop_s5_valid", 64'(dut.r_s5_valid), 64'd1);
    checkOutput("pushpop_count_before", 64'(dut.r_count), 64'(FIFO_DEPTH - 1));
    popBase = popCount;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    checkOutput("pushpop_count_after", 64'(dut.r_count), 64'(FIFO_DEPTH - 1));
    checkOutput("pushpop_one_pop", 64'(popCount - popBase), 64'd1);
    checkOutput("credit_return", 64'(ready_o), 64'd1);
    drainAll();
    checkOutput("stall_drained", 64'(popCount - popBase), 64'(FIFO_DEPTH));
    ready_i = 1'b1;
    applyStimulus(24'h000123, 24'h000456, 1'b0, 4'd9);
    drainAll();

    // Random streaming with random valid_i and ready_i
    sent = 0;
    ok = 1'b0;
    valid_i = 1'b0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      if (!valid_i || ok) begin
        valid_i = ($urandom_range(0, 9) < 7);
        randomOperand(ra); randomOperand(rb);
        a_i = ra; b_i = rb; signed_i = 1'($urandom); tag_i = TAG_W'($urandom);
      end
      ready_i = ($urandom_range(0, 9) < 7);
      ok = valid_i && ready_o;
      @(posedge clk_i);
      #1;
      if (ok) sent++;
    end
    valid_i = 1'b0;
    checkOutput("random_sent", 64'(sent), 64'd10000);
    drainAll();

    // Reset mid-stream with 3 beats in flight and 4 queued
    ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      randomOperand(ra); randomOperand(rb);
      applyStimulus(ra, rb, 1'($urandom), TAG_W'(i));
    end
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("prereset_queued", 64'(dut.r_count), 64'd4);
    rstn_i = 1'b0;
    #1;
    checkOutput("midreset_valid_o", 64'(valid_o), 64'd0);
    checkOutput("midreset_product_o", 64'(product_o), 64'd0);
    checkOutput("midreset_tag_o", 64'(tag_o), 64'd0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("postreset_ready_o", 64'(ready_o), 64'd1);
    popBase = popCount;
    ready_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    checkOutput("postreset_no_stale", 64'(popCount - popBase), 64'd0);
    checkOutput("postreset_valid_o", 64'(valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
